// File: rtl/dac_tdm_if_if.sv
// dac_tdm_if_if: sample-load and DAC-side bus bundle for dac_tdm_if
interface dac_tdm_if_if #(
  parameter int NB_CHAN    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int DAC_WIDTH  = 14
);
  localparam int SEL_W = NB_CHAN > 2 ? $clog2(NB_CHAN) : 1;
  logic                          dac_locked_i;
  logic [NB_CHAN*DATA_WIDTH-1:0] dac_dat_i;
  logic [NB_CHAN-1:0]            dac_dat_en_i;
  logic [NB_CHAN-1:0]            dac_dat_rst_i;
  logic [DAC_WIDTH-1:0]          dac_dat_o;
  logic [SEL_W-1:0]              dac_sel_o;
  logic                          dac_wrt_o;
  logic                          dac_frame_o;
  logic                          dac_rst_o;
  logic                          dac_run_o;
  modport slave (
    input  dac_locked_i, dac_dat_i, dac_dat_en_i, dac_dat_rst_i,
    output dac_dat_o, dac_sel_o, dac_wrt_o, dac_frame_o, dac_rst_o, dac_run_o
  );
  modport master (
    output dac_locked_i, dac_dat_i, dac_dat_en_i, dac_dat_rst_i,
    input  dac_dat_o, dac_sel_o, dac_wrt_o, dac_frame_o, dac_rst_o, dac_run_o
  );
endinterface

// File: rtl/dac_tdm_if.sv
// dac_tdm_if: time-multiplexes NB_CHAN held samples onto one DAC bus with lock-gated reset sequencing
module dac_tdm_if #(
  parameter int NB_CHAN    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int DAC_WIDTH  = 14,
  parameter int FORMAT     = 1,
  parameter int ROUND      = 0,
  parameter int RST_CYCLES = 4
) (
  input logic         dac_clk_i,
  input logic         dac_rst_i,
  dac_tdm_if_if.slave bus
);
  localparam int SEL_W = NB_CHAN > 2 ? $clog2(NB_CHAN) : 1;
  localparam int SHIFT = DATA_WIDTH - DAC_WIDTH;
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  // zero rounding offset turns the shared path into plain truncation
  localparam logic [DATA_WIDTH:0] HALF =
    (ROUND != 0 && SHIFT > 0) ? (DATA_WIDTH+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  typedef enum logic [1:0] {WAIT_LOCK, RESET_HOLD, RUN} state_t;
  state_t                state_q, state_d;
  logic [RC_W-1:0]       rcnt_q, rcnt_d;
  logic [SEL_W-1:0]      cnt_q, cnt_d, sel_q, sel_d;
  logic [DATA_WIDTH-1:0] hold_q [NB_CHAN];
  logic [DATA_WIDTH-1:0] hold_d [NB_CHAN];
  logic [DATA_WIDTH-1:0] frame_q [NB_CHAN];
  logic [DATA_WIDTH-1:0] frame_d [NB_CHAN];
  logic [DAC_WIDTH-1:0]  dat_q, dat_d, mid;
  logic                  wrt_q, wrt_d, frm_q, frm_d;
  logic                  to_run, emit, snap;
  function automatic logic [DAC_WIDTH-1:0] fmt(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH:0]  sum;
    logic [DAC_WIDTH:0]   sh;
    logic [DAC_WIDTH-1:0] c;
    sum = {s[DATA_WIDTH-1], s} + HALF;
    sh  = (DAC_WIDTH+1)'(sum >> SHIFT);
    c   = (sh[DAC_WIDTH] ^ sh[DAC_WIDTH-1]) ? {sh[DAC_WIDTH], {(DAC_WIDTH-1){~sh[DAC_WIDTH]}}}
                                            : sh[DAC_WIDTH-1:0];
    return FORMAT == 0 ? {~c[DAC_WIDTH-1], c[DAC_WIDTH-2:0]} :
           FORMAT == 1 ? {c[DAC_WIDTH-1], ~c[DAC_WIDTH-2:0]} : c;
  endfunction
  assign mid = fmt('0);
  always_comb begin
    to_run  = state_q == RESET_HOLD && bus.dac_locked_i && rcnt_q == RC_W'(RST_CYCLES - 1);
    emit    = state_q == RUN && bus.dac_locked_i;
    snap    = to_run || (emit && cnt_q == SEL_W'(NB_CHAN - 1));
    state_d = !bus.dac_locked_i ? WAIT_LOCK : state_q == WAIT_LOCK ? RESET_HOLD : to_run ? RUN : state_q;
    rcnt_d  = state_q == RESET_HOLD ? rcnt_q + 1'b1 : '0;
    cnt_d   = (state_q != RUN || cnt_q == SEL_W'(NB_CHAN - 1)) ? '0 : cnt_q + 1'b1;
    for (int c = 0; c < NB_CHAN; c++) begin
      hold_d[c]  = bus.dac_dat_rst_i[c] ? '0 :
                   bus.dac_dat_en_i[c] ? bus.dac_dat_i[c*DATA_WIDTH +: DATA_WIDTH] : hold_q[c];
      frame_d[c] = snap ? hold_q[c] : frame_q[c];
    end
    dat_d = emit ? fmt(frame_q[cnt_q]) : mid;
    sel_d = emit ? cnt_q : '0;
    wrt_d = emit;
    frm_d = emit && cnt_q == '0;
  end
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= WAIT_LOCK;
      rcnt_q  <= '0;
      cnt_q   <= '0;
      dat_q   <= mid;
      sel_q   <= '0;
      wrt_q   <= 1'b0;
      frm_q   <= 1'b0;
      for (int c = 0; c < NB_CHAN; c++) begin
        hold_q[c]  <= '0;
        frame_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      wrt_q   <= wrt_d;
      frm_q   <= frm_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
    end
  end
  assign bus.dac_dat_o   = dat_q;
  assign bus.dac_sel_o   = sel_q;
  assign bus.dac_wrt_o   = wrt_q;
  assign bus.dac_frame_o = frm_q;
  assign bus.dac_rst_o   = state_q != RUN;
  assign bus.dac_run_o   = state_q == RUN;
endmodule

// File: tb/tb_dac_tdm_if.sv
// tb_dac_tdm_if: directed stimulus with a queue scoreboard checking every DAC write beat
module tb_dac_tdm_if;
  logic clk, rst;
  int n_chk = 0, n_fail = 0;
  logic [16:0] exp_q [$];
  logic [16:0] mon_e;
  dac_tdm_if_if #(.NB_CHAN(4), .DATA_WIDTH(16), .DAC_WIDTH(14)) bus ();
  dac_tdm_if #(.NB_CHAN(4), .DATA_WIDTH(16), .DAC_WIDTH(14), .FORMAT(0), .ROUND(1), .RST_CYCLES(4))
    dut (.dac_clk_i(clk), .dac_rst_i(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [13:0] d, input logic [1:0] s);
    exp_q.push_back({d, s, s == 2'd0});
  endtask
  task automatic push_frame(input logic [13:0] d0, d1, d2, d3);
    push(d0, 0); push(d1, 1); push(d2, 2); push(d3, 3);
  endtask
  task automatic chk_idle(input string name);
    chk({name, "_dat"}, 32'(bus.dac_dat_o), 32'h2000);
    chk({name, "_sel"}, 32'(bus.dac_sel_o), 0);
    chk({name, "_wrt_frame_rst_run"},
        {28'd0, bus.dac_wrt_o, bus.dac_frame_o, bus.dac_rst_o, bus.dac_run_o}, 32'b0010);
  endtask
  always @(negedge clk) begin
    if (bus.dac_wrt_o === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat: unexpected write dat=%h sel=%0d", bus.dac_dat_o, bus.dac_sel_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.dac_dat_o, bus.dac_sel_o, bus.dac_frame_o} !== mon_e) begin
          n_fail++;
          $display("FAIL beat: got dat=%h sel=%0d frame=%b expected dat=%h sel=%0d frame=%b",
                   bus.dac_dat_o, bus.dac_sel_o, bus.dac_frame_o, mon_e[16:3], mon_e[2:1], mon_e[0]);
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    bus.dac_locked_i = 1'b0;
    bus.dac_dat_i = '0;
    bus.dac_dat_en_i = '0;
    bus.dac_dat_rst_i = '0;
    step(2);
    chk_idle("reset");
    rst = 1'b0;
    bus.dac_locked_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("rst_hold", {30'd0, bus.dac_rst_o, bus.dac_run_o}, 32'b10);
    end
    push_frame(14'h2000, 14'h2000, 14'h2000, 14'h2000);
    push_frame(14'h3FFF, 14'h0000, 14'h2000, 14'h2000);
    step(1);
    chk("run_entry", {29'd0, bus.dac_rst_o, bus.dac_run_o, bus.dac_wrt_o}, 32'b010);
    bus.dac_dat_i[15:0] = 16'h7FFF;
    bus.dac_dat_i[31:16] = 16'h8000;
    bus.dac_dat_en_i = 4'b0011;
    step(1);
    bus.dac_dat_en_i = '0;
    step(4);
    push_frame(14'h3FFF, 14'h0000, 14'h2040, 14'h2000);
    bus.dac_dat_i[47:32] = 16'h0100;
    bus.dac_dat_en_i = 4'b0100;
    step(1);
    bus.dac_dat_en_i = '0;
    step(1);
    push_frame(14'h3FFF, 14'h0000, 14'h2040, 14'h2080);
    bus.dac_dat_i[63:48] = 16'h0200;
    bus.dac_dat_en_i = 4'b1000;
    step(1);
    bus.dac_dat_en_i = '0;
    step(5);
    push(14'h3FFF, 0);
    push(14'h2000, 1);
    bus.dac_dat_i[31:16] = 16'h1234;
    bus.dac_dat_en_i = 4'b0010;
    bus.dac_dat_rst_i = 4'b0010;
    step(1);
    bus.dac_dat_en_i = '0;
    bus.dac_dat_rst_i = '0;
    step(4);
    bus.dac_locked_i = 1'b0;
    step(1);
    chk_idle("lock_loss");
    bus.dac_locked_i = 1'b1;
    push(14'h3FFF, 0);
    push(14'h2000, 1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("relock_hold", {30'd0, bus.dac_rst_o, bus.dac_run_o}, 32'b10);
    end
    step(1);
    chk("relock_run", {30'd0, bus.dac_rst_o, bus.dac_run_o}, 32'b01);
    step(2);
    rst = 1'b1;
    step(1);
    chk_idle("run_reset");
    rst = 1'b0;
    push_frame(14'h2000, 14'h2000, 14'h2000, 14'h2000);
    step(9);
    bus.dac_locked_i = 1'b0;
    step(3);
    chk("drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
